deep_op_sequencer: RTL and testbench
====================================

# deep_op_sequencer

Registered command sequencer that sits directly upstream of the team's deep-nested combinational operator blocks (mode/op1/op2 → result). It buffers incoming operation commands in a small FIFO and drives one command at a time onto registered operand outputs. It samples the operator's combinational result one cycle later and presents it downstream with a valid/ready handshake, tagged with its mode.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- DW, 8: operand/result width
- dos_clk  input  1  single clock, all logic on rising edge
- dos_rst  input  1  reset: synchronous, active-high
- dos_in_valid  input  1  command valid
- dos_in_ready  output  1  FIFO can accept
- dos_in_mode  input  4  operation select
- dos_in_a  input  DW  operand A
- dos_in_b  input  DW  operand B
- dos_op_mode  output  4  registered mode to downstream operator
- dos_op_a  output  DW  registered operand A to operator
- dos_op_b  output  DW  registered operand B to operator
- dos_op_result  input  DW  combinational result from operator
- dos_out_valid  output  1  result valid
- dos_out_ready  input  1  consumer accepts result
- dos_out_result  output  DW  captured result
- dos_out_tag  output  4  mode that produced dos_out_result
- dos_level  output  $clog2(DEPTH)+1  FIFO occupancy
- dos_done_cnt  output  16  results accepted (out_valid && out_ready), wraps FFFF→0000

## Operation
- Push: dos_in_valid && dos_in_ready. dos_in_ready = (dos_level < DEPTH) && !dos_rst; no dependency on same-cycle pop.
- FIFO: read/write pointers wrap modulo DEPTH. Simultaneous push and pop leaves level unchanged. A push into a full FIFO cannot occur.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: out_valid=0. If level>0: pop head, load op regs, go to ISSUE. Otherwise stay.
  - ISSUE: out_valid=0. Unconditionally capture out_result←dos_op_result and out_tag←dos_op_mode, set out_valid, go to HOLD.
  - HOLD: out_valid=1, result/tag stable. If out_ready and level>0: pop, load op regs, go to ISSUE. If out_ready and level==0: go to IDLE. If !out_ready: stay.
- Op regs change only on pop; they hold their last value otherwise.
- dos_done_cnt increments on each accepted result (HOLD && out_ready).
- Arithmetic lives entirely in the downstream operator. This block carries widths unchanged; no truncation or extension.

## Timing
- Reset (dos_rst high at an edge): state IDLE, level 0, pointers 0; all outputs 0 (op_mode/op_a/op_b/out_result/out_tag/out_valid/done_cnt/level), in_ready 0 while reset is asserted.
- Reset mid-operation: in-flight and queued commands are discarded; out_valid is 0 the cycle after the reset edge.
- Latency: command accepted in cycle T into an empty FIFO with FSM in IDLE gives op regs valid in T+2 and out_valid=1 in T+3.
- Throughput: one result per 2 cycles with dos_out_ready held high and the FIFO non-empty.
- dos_op_result must be settled by the end of the ISSUE cycle (one full clock of combinational budget).
- Backpressure: in HOLD with out_ready low, no pop occurs. The FIFO fills and in_ready drops when level==DEPTH.

## Structure
- Package deep_op_pkg:
  - state enum dos_state_e {IDLE, ISSUE, HOLD}
  - packed struct dos_cmd_t {mode[3:0], a[DW-1:0], b[DW-1:0]}, using DW=8 as a package constant
- Sub-module deep_op_fifo: parameterised DEPTH/width, push/pop/level. The sequencer FSM, op registers, output registers and counter stay in deep_op_sequencer.

## Test plan
Bench models the operator as dos_op_result = dos_op_a + dos_op_b.
- Single command, out_ready=1: mode 4'hF, a=8'h12, b=8'h34 at T → op regs 4'hF/12/34 at T+2; out_valid at T+3 with result 8'h46, tag 4'hF; done_cnt=1 at T+4.
- Burst of 5 commands (a=1..5, b=8'h10), out_ready=0:
  - in_ready drops after 4 accepted; level=4; first result 8'h11 held in HOLD.
  - Raise out_ready: results 11,12,13,14,15 in order, spaced 2 cycles apart.
- Simultaneous push and pop at level 2 → level stays 2; pointer wrap after 6 total pushes with DEPTH=4; all results in order.
- Wrap: a=8'hFF, b=8'h01 → result 8'h00. Preload done_cnt to FFFF via 65535 accepts (or force) → next accept gives 0000.
- Reset mid-operation: assert dos_rst with 3 queued commands and out_valid=1 → next cycle all outputs 0, level 0; a new command after release gives a correct result with latency 3.

Source files
------------

// File: rtl/deep_op_pkg.sv
// Shared types for the deep-operator command sequencer: FSM state encoding and
// the command word layout carried through the command FIFO.
package deep_op_pkg;

    localparam int DOS_DW = 8;
    localparam int DOS_MW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } dos_state_e;

    // Field order matches the {mode, a, b} packing used on the FIFO data path.
    typedef struct packed {
        logic [DOS_MW-1:0] mode;
        logic [DOS_DW-1:0] a;
        logic [DOS_DW-1:0] b;
    } dos_cmd_t;

endpackage

// File: rtl/deep_op_fifo.sv
// Command FIFO: power-of-two depth, head visible combinationally, one-cycle write.
// Caller guarantees no push when full and no pop when empty.
module deep_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_level    = r_level;

endmodule

// File: rtl/deep_op_sequencer.sv
// Feeds a combinational operator one queued command at a time from registered
// operands, captures its result a cycle later and offers it with valid/ready.
module deep_op_sequencer
    import deep_op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                    dos_clk,
    input  logic                    dos_rst,
    input  logic                    dos_in_valid,
    output logic                    dos_in_ready,
    input  logic [3:0]              dos_in_mode,
    input  logic [DW-1:0]           dos_in_a,
    input  logic [DW-1:0]           dos_in_b,
    output logic [3:0]              dos_op_mode,
    output logic [DW-1:0]           dos_op_a,
    output logic [DW-1:0]           dos_op_b,
    input  logic [DW-1:0]           dos_op_result,
    output logic                    dos_out_valid,
    input  logic                    dos_out_ready,
    output logic [DW-1:0]           dos_out_result,
    output logic [3:0]              dos_out_tag,
    output logic [$clog2(DEPTH):0]  dos_level,
    output logic [15:0]             dos_done_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = 4 + 2 * DW;

    dos_state_e    r_state;
    logic [3:0]    r_op_mode;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic          r_out_valid;
    logic [DW-1:0] r_out_result;
    logic [3:0]    r_out_tag;
    logic [15:0]   r_done_cnt;

    logic [LW-1:0] w_level;
    logic [CW-1:0] w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_has_cmd;
    logic          w_accept;

    // Ready looks only at the registered level, never at a same-cycle pop.
    assign dos_in_ready = (w_level < LW'(DEPTH)) && !dos_rst;
    assign w_push       = dos_in_valid && dos_in_ready;
    assign w_has_cmd    = (w_level != '0);
    assign w_accept     = (r_state == HOLD) && dos_out_ready;
    assign w_pop        = w_has_cmd && ((r_state == IDLE) || w_accept);

    deep_op_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .i_clk      (dos_clk),
        .i_rst      (dos_rst),
        .i_push     (w_push),
        .i_push_dat ({dos_in_mode, dos_in_a, dos_in_b}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_level    (w_level)
    );

    always_ff @(posedge dos_clk) begin
        if (dos_rst) begin
            r_state      <= IDLE;
            r_op_mode    <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_done_cnt   <= '0;
        end else begin
            if (w_pop) begin
                {r_op_mode, r_op_a, r_op_b} <= w_head;
            end
            case (r_state)
                IDLE: begin
                    if (w_has_cmd) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Operator has had the whole cycle to settle on the op regs.
                    r_out_result <= dos_op_result;
                    r_out_tag    <= r_op_mode;
                    r_out_valid  <= 1'b1;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    if (dos_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 16'd1;
                        r_state     <= w_has_cmd ? ISSUE : IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dos_op_mode    = r_op_mode;
    assign dos_op_a       = r_op_a;
    assign dos_op_b       = r_op_b;
    assign dos_out_valid  = r_out_valid;
    assign dos_out_result = r_out_result;
    assign dos_out_tag    = r_out_tag;
    assign dos_level      = w_level;
    assign dos_done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_deep_op_sequencer.sv
// Directed and random stimulus for deep_op_sequencer; the operator is modelled as a + b
// and results are scored against a queue of accepted commands.
module tb_deep_op_sequencer;
    import deep_op_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          dos_clk = 1'b0;
    logic          dos_rst;
    logic          dos_in_valid;
    logic          dos_in_ready;
    logic [3:0]    dos_in_mode;
    logic [DW-1:0] dos_in_a;
    logic [DW-1:0] dos_in_b;
    logic [3:0]    dos_op_mode;
    logic [DW-1:0] dos_op_a;
    logic [DW-1:0] dos_op_b;
    logic [DW-1:0] dos_op_result;
    logic          dos_out_valid;
    logic          dos_out_ready;
    logic [DW-1:0] dos_out_result;
    logic [3:0]    dos_out_tag;
    logic [2:0]    dos_level;
    logic [15:0]   dos_done_cnt;

    always #5 dos_clk = ~dos_clk;

    assign dos_op_result = dos_op_a + dos_op_b;

    deep_op_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .dos_clk        (dos_clk),
        .dos_rst        (dos_rst),
        .dos_in_valid   (dos_in_valid),
        .dos_in_ready   (dos_in_ready),
        .dos_in_mode    (dos_in_mode),
        .dos_in_a       (dos_in_a),
        .dos_in_b       (dos_in_b),
        .dos_op_mode    (dos_op_mode),
        .dos_op_a       (dos_op_a),
        .dos_op_b       (dos_op_b),
        .dos_op_result  (dos_op_result),
        .dos_out_valid  (dos_out_valid),
        .dos_out_ready  (dos_out_ready),
        .dos_out_result (dos_out_result),
        .dos_out_tag    (dos_out_tag),
        .dos_level      (dos_level),
        .dos_done_cnt   (dos_done_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    dos_cmd_t    m_q[$];
    logic [15:0] m_done;
    int          cyc;
    int          last_acc;
    bit          chk_spacing;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake that will complete at the coming edge, then advance the model.
    task automatic cycle();
        bit       push_f;
        bit       acc_f;
        dos_cmd_t c;
        dos_cmd_t h;
        #1;
        push_f = dos_in_valid && dos_in_ready;
        acc_f  = dos_out_valid && dos_out_ready && !dos_rst;
        c.mode = dos_in_mode;
        c.a    = dos_in_a;
        c.b    = dos_in_b;
        if (acc_f) begin
            if (m_q.size() == 0) begin
                check("unexpected_result", dos_out_valid, 0);
            end else begin
                h = m_q.pop_front();
                check("result", dos_out_result, 8'(h.a + h.b));
                check("tag", dos_out_tag, h.mode);
            end
            if (chk_spacing && last_acc >= 0) begin
                check("spacing", cyc - last_acc, 2);
            end
            last_acc = cyc;
        end
        @(posedge dos_clk);
        #1;
        cyc++;
        if (dos_rst) begin
            m_q.delete();
            m_done = '0;
        end else begin
            if (push_f) m_q.push_back(c);
            if (acc_f)  m_done++;
        end
        check("done_cnt", dos_done_cnt, m_done);
    endtask

    task automatic drain();
        dos_in_valid  = 1'b0;
        dos_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (m_q.size() == 0 && !dos_out_valid) break;
            cycle();
        end
        check("drain_empty", m_q.size(), 0);
        check("drain_out_valid", dos_out_valid, 0);
    endtask

    // Needs an idle, empty sequencer with out_ready already high.
    task automatic single_cmd(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        dos_in_valid = 1'b1;
        dos_in_mode  = m;
        dos_in_a     = a;
        dos_in_b     = b;
        cycle();
        dos_in_valid = 1'b0;
        check("lat1_out_valid", dos_out_valid, 0);
        check("lat1_level", dos_level, 1);
        cycle();
        check("lat2_op_mode", dos_op_mode, m);
        check("lat2_op_a", dos_op_a, a);
        check("lat2_op_b", dos_op_b, b);
        check("lat2_out_valid", dos_out_valid, 0);
        cycle();
        check("lat3_out_valid", dos_out_valid, 1);
        check("lat3_result", dos_out_result, 8'(a + b));
        check("lat3_tag", dos_out_tag, m);
        cycle();
        check("lat4_out_valid", dos_out_valid, 0);
    endtask

    task automatic push_one(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        int w;
        dos_in_valid = 1'b1;
        dos_in_mode  = m;
        dos_in_a     = a;
        dos_in_b     = b;
        w = 0;
        while (!dos_in_ready && w < 20) begin
            cycle();
            w++;
        end
        if (w >= 20) check("push_ready_timeout", dos_in_ready, 1);
        cycle();
        dos_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dos_rst       = 1'b1;
        dos_in_valid  = 1'b0;
        dos_in_mode   = '0;
        dos_in_a      = '0;
        dos_in_b      = '0;
        dos_out_ready = 1'b0;
        m_done        = '0;
        cyc           = 0;
        last_acc      = -1;
        chk_spacing   = 1'b0;

        cycle();
        cycle();
        check("rst_in_ready", dos_in_ready, 0);
        check("rst_level", dos_level, 0);
        check("rst_out_valid", dos_out_valid, 0);
        check("rst_op_mode", dos_op_mode, 0);
        check("rst_op_a", dos_op_a, 0);
        check("rst_op_b", dos_op_b, 0);
        check("rst_out_result", dos_out_result, 0);
        check("rst_out_tag", dos_out_tag, 0);
        check("rst_done_cnt", dos_done_cnt, 0);

        dos_rst       = 1'b0;
        dos_out_ready = 1'b1;
        #1;
        check("release_in_ready", dos_in_ready, 1);

        single_cmd(4'hF, 8'h12, 8'h34);
        check("single_done_cnt", dos_done_cnt, 1);

        // Burst against a stalled consumer: first command sits in HOLD, four fill the FIFO.
        dos_out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push_one(4'(k), 8'(k), 8'h10);
        check("burst_level", dos_level, 4);
        check("burst_in_ready", dos_in_ready, 0);
        check("burst_out_valid", dos_out_valid, 1);
        check("burst_first_result", dos_out_result, 8'h11);
        cycle();
        check("burst_hold_result", dos_out_result, 8'h11);
        check("burst_hold_level", dos_level, 4);
        chk_spacing = 1'b1;
        last_acc    = -1;
        drain();
        chk_spacing = 1'b0;
        check("burst_done_cnt", dos_done_cnt, 6);

        // Simultaneous push and pop at level 2, including an 8-bit wrapping sum.
        dos_out_ready = 1'b0;
        push_one(4'h3, 8'hFF, 8'h01);
        push_one(4'h5, 8'h20, 8'h22);
        push_one(4'h6, 8'h07, 8'h08);
        check("sim_level_before", dos_level, 2);
        check("sim_out_valid", dos_out_valid, 1);
        check("wrap_result", dos_out_result, 8'h00);
        check("wrap_tag", dos_out_tag, 4'h3);
        dos_in_valid  = 1'b1;
        dos_in_mode   = 4'h9;
        dos_in_a      = 8'h40;
        dos_in_b      = 8'h02;
        dos_out_ready = 1'b1;
        cycle();
        dos_in_valid = 1'b0;
        check("sim_level_after", dos_level, 2);
        drain();

        // Done counter rollover.
        force dut.r_done_cnt = 16'hFFFF;
        #1;
        release dut.r_done_cnt;
        m_done = 16'hFFFF;
        single_cmd(4'($urandom), 8'($urandom), 8'($urandom));
        check("done_wrap", dos_done_cnt, 0);

        // Reset with one result held and three commands queued.
        dos_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_one(4'($urandom), 8'($urandom), 8'($urandom));
        check("mid_level", dos_level, 3);
        check("mid_out_valid", dos_out_valid, 1);
        dos_rst       = 1'b1;
        dos_in_valid  = 1'b1;
        dos_out_ready = 1'b1;
        cycle();
        dos_in_valid = 1'b0;
        check("mid_rst_out_valid", dos_out_valid, 0);
        check("mid_rst_level", dos_level, 0);
        check("mid_rst_in_ready", dos_in_ready, 0);
        check("mid_rst_op_mode", dos_op_mode, 0);
        check("mid_rst_op_a", dos_op_a, 0);
        check("mid_rst_op_b", dos_op_b, 0);
        check("mid_rst_out_result", dos_out_result, 0);
        check("mid_rst_out_tag", dos_out_tag, 0);
        check("mid_rst_done_cnt", dos_done_cnt, 0);
        dos_rst = 1'b0;
        #1;
        check("mid_release_in_ready", dos_in_ready, 1);
        single_cmd(4'($urandom), 8'($urandom), 8'($urandom));

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++) begin
            dos_in_valid  = 1'($urandom_range(0, 1));
            dos_in_mode   = 4'($urandom);
            dos_in_a      = 8'($urandom);
            dos_in_b      = 8'($urandom);
            dos_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        check("final_level", dos_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
